// File: rtl/mlp_stream_loader_pkg.sv
// Shared opcodes, FSM states and bank selection for the MLP stream loader.
package mlp_stream_loader_pkg;

  typedef enum logic [7:0] {
    OP_LOAD_IN = 8'h01,
    OP_LOAD_W  = 8'h02,
    OP_LOAD_B  = 8'h03,
    OP_RUN     = 8'h04,
    OP_CFG     = 8'h05
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CFG,
    ST_KICK,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    BANK_IN,
    BANK_W,
    BANK_B
  } bank_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h05);
  endfunction

  function automatic bank_e op_to_bank(input logic [7:0] op);
    case (op)
      OP_LOAD_W: return BANK_W;
      OP_LOAD_B: return BANK_B;
      default:   return BANK_IN;
    endcase
  endfunction

endpackage

// File: rtl/mlp_stream_loader_if.sv
// Byte stream (valid/ready) from the host into the loader.
interface mlp_stream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/mlp_stream_loader.sv
// Decodes a framed command byte stream into accelerator BRAM writes, config and run control.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for an opcode byte
// HDR     | collecting addr_lo/addr_hi/len_lo/len_hi of a LOAD frame
// DATA    | streaming len payload bytes into the selected bank
// CFG     | collecting nin_lo/nin_hi/nout_lo/nout_hi
// KICK    | waiting for the accelerator to go idle, then pulsing start
// RUN     | waiting for done or timeout; stream stalled
module mlp_stream_loader
  import mlp_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned RUN_TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  mlp_stream_loader_if.slave s,
  output logic [ADDR_W-1:0] input_addr,
  output logic [7:0]        input_data,
  output logic              input_we,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [7:0]        weight_data,
  output logic              weight_we,
  output logic [ADDR_W-1:0] bias_addr,
  output logic [7:0]        bias_data,
  output logic              bias_we,
  output logic [15:0]       num_inputs,
  output logic [15:0]       num_outputs,
  output logic              start,
  input  logic              mlp_busy,
  input  logic              mlp_done,
  output logic              run_done,
  output logic              loader_busy,
  output logic              err_opcode,
  output logic              err_timeout,
  input  logic              err_clear
);

  state_e            state_q, state_d;
  logic [23:0]       hdr_q;
  logic [1:0]        idx_q;
  bank_e             bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [31:0]       run_cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              ready;
  logic              accept;
  logic              hdr_last;
  logic              timeout_hit;
  logic [ADDR_W-1:0] hdr_base;
  logic [ADDR_W-1:0] hdr_len;

  // Only three header bytes are stored; the fourth is taken straight off the stream.
  assign accept      = s.s_valid & ready;
  assign hdr_last    = accept && (idx_q == 2'd3);
  assign hdr_base    = ADDR_W'({hdr_q[15:8], hdr_q[7:0]});
  assign hdr_len     = ADDR_W'({s.s_data, hdr_q[23:16]});
  assign timeout_hit = (RUN_TIMEOUT != 0) && (run_cnt_q == 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept) begin
          case (s.s_data)
            OP_LOAD_IN, OP_LOAD_W, OP_LOAD_B: state_d = ST_HDR;
            OP_CFG:                           state_d = ST_CFG;
            OP_RUN:                           state_d = ST_KICK;
            default:                          state_d = ST_IDLE;
          endcase
        end
      ST_HDR:  if (hdr_last) state_d = (hdr_len == '0) ? ST_IDLE : ST_DATA;
      ST_DATA: if (accept && (len_q == ADDR_W'(1))) state_d = ST_IDLE;
      ST_CFG:  if (hdr_last) state_d = ST_IDLE;
      ST_KICK: if (!mlp_busy) state_d = ST_RUN;
      ST_RUN:  if (mlp_done || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    loader_busy = 1'b1;
    case (state_q)
      ST_IDLE:                 begin ready = 1'b1; loader_busy = 1'b0; end
      ST_HDR, ST_DATA, ST_CFG: ready = 1'b1;
      default:                 ready = 1'b0;
    endcase
  end

  assign s.s_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q       <= '0;
      idx_q       <= '0;
      bank_q      <= BANK_IN;
      addr_q      <= '0;
      len_q       <= '0;
      run_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      input_we    <= 1'b0;
      weight_we   <= 1'b0;
      bias_we     <= 1'b0;
      start       <= 1'b0;
      run_done    <= 1'b0;
      num_inputs  <= '0;
      num_outputs <= '0;
    end else begin
      input_we  <= 1'b0;
      weight_we <= 1'b0;
      bias_we   <= 1'b0;
      start     <= 1'b0;
      run_done  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (accept) bank_q <= op_to_bank(s.s_data);
        end
        ST_HDR, ST_CFG: begin
          if (accept) begin
            hdr_q <= {s.s_data, hdr_q[23:8]};
            idx_q <= idx_q + 2'd1;
          end
          if (hdr_last && (state_q == ST_HDR)) begin
            addr_q <= hdr_base;
            len_q  <= hdr_len;
          end
          if (hdr_last && (state_q == ST_CFG)) begin
            num_inputs  <= {hdr_q[15:8], hdr_q[7:0]};
            num_outputs <= {s.s_data, hdr_q[23:16]};
          end
        end
        ST_DATA: begin
          if (accept) begin
            wr_addr_q <= addr_q;
            wr_data_q <= s.s_data;
            addr_q    <= addr_q + ADDR_W'(1);
            len_q     <= len_q - ADDR_W'(1);
            case (bank_q)
              BANK_W:  weight_we <= 1'b1;
              BANK_B:  bias_we   <= 1'b1;
              default: input_we  <= 1'b1;
            endcase
          end
        end
        ST_KICK: begin
          if (!mlp_busy) begin
            start     <= 1'b1;
            run_cnt_q <= RUN_TIMEOUT;
          end
        end
        ST_RUN: begin
          if (run_cnt_q != '0) run_cnt_q <= run_cnt_q - 32'd1;
          if (mlp_done || timeout_hit) run_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky errors: a new error in the same cycle as err_clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && accept && !is_legal_op(s.s_data)) err_opcode <= 1'b1;
      else if (err_clear)                                          err_opcode <= 1'b0;
      if ((state_q == ST_RUN) && !mlp_done && timeout_hit) err_timeout <= 1'b1;
      else if (err_clear)                                  err_timeout <= 1'b0;
    end
  end

  assign input_addr  = wr_addr_q;
  assign input_data  = wr_data_q;
  assign weight_addr = wr_addr_q;
  assign weight_data = wr_data_q;
  assign bias_addr   = wr_addr_q;
  assign bias_data   = wr_data_q;

endmodule

// File: tb/tb_mlp_stream_loader.sv
// Directed bench for mlp_stream_loader: loads, config, run handshake, timeout, errors, reset.
module tb_mlp_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] input_addr, weight_addr, bias_addr;
  logic [7:0]  input_data, weight_data, bias_data;
  logic        input_we, weight_we, bias_we;
  logic [15:0] num_inputs, num_outputs;
  logic        start, run_done, loader_busy, err_opcode, err_timeout;
  logic        mlp_busy = 1'b0;
  logic        mlp_done = 1'b0;
  logic        err_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_in = 0, cnt_w = 0, cnt_b = 0, cnt_start = 0, cnt_done = 0;

  always #5 clk = ~clk;

  mlp_stream_loader_if sif ();

  mlp_stream_loader #(.ADDR_W(16), .RUN_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .s(sif),
    .input_addr(input_addr), .input_data(input_data), .input_we(input_we),
    .weight_addr(weight_addr), .weight_data(weight_data), .weight_we(weight_we),
    .bias_addr(bias_addr), .bias_data(bias_data), .bias_we(bias_we),
    .num_inputs(num_inputs), .num_outputs(num_outputs), .start(start),
    .mlp_busy(mlp_busy), .mlp_done(mlp_done), .run_done(run_done),
    .loader_busy(loader_busy), .err_opcode(err_opcode), .err_timeout(err_timeout),
    .err_clear(err_clear)
  );

  always @(negedge clk) begin
    if (input_we)  cnt_in++;
    if (weight_we) cnt_w++;
    if (bias_we)   cnt_b++;
    if (start)     cnt_start++;
    if (run_done)  cnt_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    sif.s_data  = b;
    sif.s_valid = 1'b1;
    tick();
    sif.s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_in, s_w, s_b, s_st, s_dn;
    logic [7:0] wd [3];
    wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3;
    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;

    repeat (3) tick();
    chk("rst_s_ready", sif.s_ready, 1);
    chk("rst_busy", loader_busy, 0);
    chk("rst_strobes", {input_we, weight_we, bias_we, start, run_done}, 0);
    chk("rst_errs", {err_opcode, err_timeout}, 0);
    chk("rst_cfg", {num_inputs, num_outputs}, 0);
    chk("rst_addr", weight_addr, 0);
    rst_n = 1'b1;
    tick();

    // LOAD_W addr 0x0010 len 3
    s_in = cnt_in; s_w = cnt_w; s_b = cnt_b;
    send(8'h02);
    chk("ldw_busy_hdr", loader_busy, 1);
    send(8'h10); send(8'h00); send(8'h03); send(8'h00);
    for (int i = 0; i < 3; i++) begin
      send(wd[i]);
      chk("ldw_we", weight_we, 1);
      chk("ldw_addr", weight_addr, 32'h10 + i);
      chk("ldw_data", weight_data, wd[i]);
      chk("ldw_other_we", {input_we, bias_we}, 0);
    end
    chk("ldw_idle", loader_busy, 0);
    tick();
    chk("ldw_we_off", weight_we, 0);
    chk("ldw_cnt_w", cnt_w - s_w, 3);
    chk("ldw_cnt_other", (cnt_in - s_in) + (cnt_b - s_b), 0);

    // LOAD_IN addr 0xFFFE len 4 with gaps, wraps address
    s_in = cnt_in; s_w = cnt_w; s_b = cnt_b;
    send(8'h01); send(8'hFE); send(8'hFF); send(8'h04); send(8'h00);
    send(8'hD0);
    chk("ldi_we0", input_we, 1);
    chk("ldi_addr0", input_addr, 16'hFFFE);
    chk("ldi_data0", input_data, 8'hD0);
    tick();
    chk("ldi_gap_we", input_we, 0);
    send(8'hD1);
    chk("ldi_addr1", input_addr, 16'hFFFF);
    tick(); tick();
    chk("ldi_gap2_we", input_we, 0);
    send(8'hD2);
    chk("ldi_addr2", input_addr, 16'h0000);
    chk("ldi_data2", input_data, 8'hD2);
    send(8'hD3);
    chk("ldi_addr3", input_addr, 16'h0001);
    chk("ldi_idle", loader_busy, 0);
    tick();
    chk("ldi_cnt_in", cnt_in - s_in, 4);
    chk("ldi_cnt_other", (cnt_w - s_w) + (cnt_b - s_b), 0);

    // CFG nin=64 nout=10
    send(8'h05); send(8'h40); send(8'h00); send(8'h0A);
    chk("cfg_hold", num_inputs, 0);
    send(8'h00);
    chk("cfg_nin", num_inputs, 64);
    chk("cfg_nout", num_outputs, 10);
    chk("cfg_idle", loader_busy, 0);

    // LOAD_B len 0: no strobes
    s_b = cnt_b;
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    chk("ld0_busy", loader_busy, 1);
    send(8'h00);
    chk("ld0_idle", loader_busy, 0);
    chk("ld0_ready", sif.s_ready, 1);
    repeat (3) tick();
    chk("ld0_cnt_b", cnt_b - s_b, 0);

    // RUN: busy for 5 cycles, stale done ignored, then done
    s_st = cnt_start; s_dn = cnt_done;
    mlp_busy = 1'b1;
    mlp_done = 1'b1;
    send(8'h04);
    chk("kick_ready", sif.s_ready, 0);
    chk("kick_start", start, 0);
    repeat (4) tick();
    mlp_done = 1'b0;
    tick();
    chk("kick_hold", {start, run_done, loader_busy}, 3'b001);
    mlp_busy = 1'b0;
    tick();
    chk("run_start", start, 1);
    chk("run_ready0", sif.s_ready, 0);
    tick();
    chk("run_start_off", start, 0);
    tick(); tick();
    chk("run_ready1", sif.s_ready, 0);
    mlp_done = 1'b1;
    tick();
    chk("run_done", run_done, 1);
    chk("run_idle", {loader_busy, sif.s_ready, err_timeout}, 3'b010);
    mlp_done = 1'b0;
    tick();
    chk("run_done_off", run_done, 0);
    chk("run_cnt_start", cnt_start - s_st, 1);
    chk("run_cnt_done", cnt_done - s_dn, 1);

    // RUN timeout after 100 cycles
    send(8'h04);
    tick();
    chk("to_start", start, 1);
    s_dn = cnt_done;
    repeat (99) tick();
    chk("to_no_early", cnt_done - s_dn, 0);
    chk("to_still_run", {loader_busy, err_timeout}, 2'b10);
    tick();
    chk("to_done", run_done, 1);
    chk("to_err", err_timeout, 1);
    chk("to_idle", loader_busy, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_clear", err_timeout, 0);

    // Illegal opcode
    s_in = cnt_in; s_w = cnt_w; s_b = cnt_b;
    send(8'h7F);
    chk("op_err", err_opcode, 1);
    chk("op_idle", {loader_busy, sif.s_ready}, 2'b01);
    tick();
    chk("op_no_writes", (cnt_in - s_in) + (cnt_w - s_w) + (cnt_b - s_b), 0);
    sif.s_data  = 8'h99;
    sif.s_valid = 1'b1;
    err_clear   = 1'b1;
    tick();
    sif.s_valid = 1'b0;
    err_clear   = 1'b0;
    chk("op_set_wins", err_opcode, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("op_clear", err_opcode, 0);

    // Reset mid-DATA
    send(8'h01); send(8'h00); send(8'h00); send(8'h08); send(8'h00);
    send(8'h11); send(8'h22);
    chk("mr_we", input_we, 1);
    chk("mr_addr", input_addr, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_strobes", {input_we, weight_we, bias_we, start}, 0);
    chk("mr_ready", sif.s_ready, 1);
    chk("mr_busy", loader_busy, 0);
    chk("mr_cfg", num_inputs, 0);
    s_in = cnt_in; s_st = cnt_start;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_quiet", (cnt_in - s_in) + (cnt_start - s_st), 0);
    chk("mr_idle", loader_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
